// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock/flush controller: load-use stalls, PC-redirect flushes and memory-busy freezes.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int LOAD_STALLS      = 1,
   parameter int REDIRECT_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  ifidOP1,
   input  logic [3:0]  ifidOP2,
   input  logic        ifidUsesOP2,
   input  logic [3:0]  idexOP1,
   input  logic        idexMemRead,
   input  logic [2:0]  idexregWrite,
   input  logic        branchTaken,
   input  logic        memBusy,
   output logic        pcWrite,
   output logic        ifidWrite,
   output logic        idexWrite,
   output logic        exmemWrite,
   output logic        ifidFlush,
   output logic        idexFlush,
   output logic [1:0]  state,
   output logic [15:0] stallCycles
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LDSTALL  = 2'b01,
      MEMWAIT  = 2'b10,
      REDIRECT = 2'b11
   } state_t;

   localparam logic [2:0] LS_M1 = 3'(LOAD_STALLS - 1);
   localparam logic [2:0] RB_M1 = 3'(REDIRECT_BUBBLES - 1);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       redirect, load_use;
   logic       unused_regwrite_class;

   // Only the special/PC-write class bit matters for redirect detection.
   assign unused_regwrite_class = ^idexregWrite[1:0];

   assign redirect = branchTaken | (idexregWrite[2] & (idexOP1 == 4'hF));
   assign load_use = idexMemRead & (idexOP1 != 4'h0) &
                     ((idexOP1 == ifidOP1) | (ifidUsesOP2 & (idexOP1 == ifidOP2)));

   always_comb begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      ifidFlush  = 1'b0;
      idexFlush  = 1'b0;
      state_d    = state_q;
      cnt_d      = cnt_q;
      if (reset) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexWrite  = 1'b0;
         exmemWrite = 1'b0;
         ifidFlush  = 1'b1;
         idexFlush  = 1'b1;
         state_d    = RUN;
         cnt_d      = 3'd0;
      end else if (memBusy) begin
         // Freeze; an in-flight stall/redirect sequence holds its position.
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexWrite  = 1'b0;
         exmemWrite = 1'b0;
         if (state_q == RUN || state_q == MEMWAIT) state_d = MEMWAIT;
      end else if (redirect) begin
         ifidFlush = 1'b1;
         idexFlush = 1'b1;
         if (REDIRECT_BUBBLES > 1) begin
            state_d = REDIRECT;
            cnt_d   = RB_M1;
         end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      end else if (state_q == LDSTALL) begin
         pcWrite   = 1'b0;
         ifidWrite = 1'b0;
         idexFlush = 1'b1;
         cnt_d     = cnt_q - 3'd1;
         if (cnt_q == 3'd1) state_d = RUN;
      end else if (state_q == REDIRECT) begin
         ifidFlush = 1'b1;
         cnt_d     = cnt_q - 3'd1;
         if (cnt_q == 3'd1) state_d = RUN;
      end else if (load_use) begin
         pcWrite   = 1'b0;
         ifidWrite = 1'b0;
         idexFlush = 1'b1;
         if (LOAD_STALLS > 1) begin
            state_d = LDSTALL;
            cnt_d   = LS_M1;
         end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      end else begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk) begin
      if (reset)
         perf_q <= 16'h0000;
      else if (!pcWrite && perf_q != 16'hFFFF)
         perf_q <= perf_q + 16'h0001;
   end

   assign stallCycles = perf_q;
`else
   assign stallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (LOAD_STALLS=2, REDIRECT_BUBBLES=3).
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ifidOP1, ifidOP2, idexOP1;
   logic        ifidUsesOP2, idexMemRead, branchTaken, memBusy;
   logic [2:0]  idexregWrite;
   logic        pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush;
   logic [1:0]  state;
   logic [15:0] stallCycles;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_perf = 16'h0000;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.LOAD_STALLS(2), .REDIRECT_BUBBLES(3)) dut (
      .clk(clk), .reset(reset),
      .ifidOP1(ifidOP1), .ifidOP2(ifidOP2), .ifidUsesOP2(ifidUsesOP2),
      .idexOP1(idexOP1), .idexMemRead(idexMemRead), .idexregWrite(idexregWrite),
      .branchTaken(branchTaken), .memBusy(memBusy),
      .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
      .exmemWrite(exmemWrite), .ifidFlush(ifidFlush), .idexFlush(idexFlush),
      .state(state), .stallCycles(stallCycles)
   );

   task automatic idle();
      ifidOP1 = 4'd0; ifidOP2 = 4'd0; ifidUsesOP2 = 1'b0;
      idexOP1 = 4'd0; idexMemRead = 1'b0; idexregWrite = 3'b000;
      branchTaken = 1'b0; memBusy = 1'b0;
   endtask

   // exp = {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush}
   task automatic step(input string tag, input logic [5:0] exp, input logic [1:0] exp_st);
      logic [5:0]  obs;
      logic [15:0] perf_exp_now;
      @(negedge clk);
      obs = {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s ctrl observed %b expected %b", tag, obs, exp);
      end
      checks++;
      assert (state === exp_st) else begin
         errors++;
         $error("FAIL %s state observed %b expected %b", tag, state, exp_st);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_exp_now = exp_perf;
`else
      perf_exp_now = 16'h0000;
`endif
      checks++;
      assert (stallCycles === perf_exp_now) else begin
         errors++;
         $error("FAIL %s stallCycles observed %0d expected %0d", tag, stallCycles, perf_exp_now);
      end
      if (reset) exp_perf = 16'h0000;
      else if (!exp[5] && exp_perf != 16'hFFFF) exp_perf = exp_perf + 16'h0001;
      @(posedge clk);
      #1;
   endtask

   localparam logic [5:0] C_RST   = 6'b0000_11;
   localparam logic [5:0] C_RUN   = 6'b1111_00;
   localparam logic [5:0] C_LD    = 6'b0011_01;
   localparam logic [5:0] C_RDIR  = 6'b1111_11;
   localparam logic [5:0] C_RBUB  = 6'b1111_10;
   localparam logic [5:0] C_FRZ   = 6'b0000_00;

   initial begin
      idle();
      reset = 1'b1;
      #1;
      step("reset0", C_RST, 2'b00);
      step("reset1", C_RST, 2'b00);
      reset = 1'b0;
      step("run_idle", C_RUN, 2'b00);

      // load-use on OP1, two stall cycles
      idexMemRead = 1'b1; idexOP1 = 4'd3; ifidOP1 = 4'd3;
      step("lu_op1_c0", C_LD, 2'b00);
      idle();
      step("lu_op1_c1", C_LD, 2'b01);
      step("lu_op1_done", C_RUN, 2'b00);

      // R0 destination never stalls
      idexMemRead = 1'b1; idexOP1 = 4'd0; ifidOP1 = 4'd0;
      step("lu_r0", C_RUN, 2'b00);
      // OP2 match ignored unless OP2 is used
      idexOP1 = 4'd5; ifidOP1 = 4'd2; ifidOP2 = 4'd5; ifidUsesOP2 = 1'b0;
      step("lu_op2_unused", C_RUN, 2'b00);
      ifidUsesOP2 = 1'b1;
      step("lu_op2_c0", C_LD, 2'b00);
      idle();
      // memBusy mid-LDSTALL: freeze 4 cycles, cnt held
      memBusy = 1'b1;
      step("ld_busy0", C_FRZ, 2'b01);
      step("ld_busy1", C_FRZ, 2'b01);
      step("ld_busy2", C_FRZ, 2'b01);
      step("ld_busy3", C_FRZ, 2'b01);
      memBusy = 1'b0;
      step("ld_resume", C_LD, 2'b01);
      step("ld_resume_done", C_RUN, 2'b00);

      // branch beats simultaneous load-use; three IF/ID flushes
      branchTaken = 1'b1; idexMemRead = 1'b1; idexOP1 = 4'd7; ifidOP1 = 4'd7;
      step("br_vs_lu", C_RDIR, 2'b00);
      idle();
      step("br_bub1", C_RBUB, 2'b11);
      step("br_bub2", C_RBUB, 2'b11);
      step("br_done", C_RUN, 2'b00);

      // write to R15 needs the special class bit
      idexregWrite = 3'b011; idexOP1 = 4'hF;
      step("r15_noclass", C_RUN, 2'b00);
      idexregWrite = 3'b100;
      step("r15_c0", C_RDIR, 2'b00);
      idle();
      step("r15_bub1", C_RBUB, 2'b11);
      step("r15_bub2", C_RBUB, 2'b11);
      step("r15_done", C_RUN, 2'b00);

      // MEMWAIT then immediate evaluation as RUN on release
      memBusy = 1'b1;
      step("mw_c0", C_FRZ, 2'b00);
      step("mw_c1", C_FRZ, 2'b10);
      memBusy = 1'b0; idexMemRead = 1'b1; idexOP1 = 4'd9; ifidOP1 = 4'd9;
      step("mw_release_lu", C_LD, 2'b10);
      idle();
      step("mw_ld_c1", C_LD, 2'b01);
      step("mw_done", C_RUN, 2'b00);

      // redirect aborts LDSTALL, then reset aborts REDIRECT
      idexMemRead = 1'b1; idexOP1 = 4'd4; ifidOP1 = 4'd4;
      step("abort_lu", C_LD, 2'b00);
      idle();
      branchTaken = 1'b1;
      step("abort_br", C_RDIR, 2'b01);
      branchTaken = 1'b0;
      step("abort_bub1", C_RBUB, 2'b11);
      reset = 1'b1;
      step("abort_reset", C_RST, 2'b11);
      reset = 1'b0;
      step("post_reset", C_RUN, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
